// File: rtl/kernel3_gmem_pkg.sv
// Shared constants, types and helpers for the gmem SRL FIFO.
// Holds default sizing, a clog2 helper and the occupancy type.
package kernel3_gmem_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_DEPTH      = 64;
  localparam int DEF_CNT_WIDTH  = 7;

  typedef logic [DEF_CNT_WIDTH-1:0] occ_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int x = v - 1; x > 0; x = x >> 1)
      r++;
    return r;
  endfunction

endpackage

// File: rtl/kernel3_gmem_srl_store.sv
// Reset-free shift array of ENTRIES words; entry 0 takes wr_data.
// Ports: clk, shift_en, wr_data in; rd_addr in, rd_data out (comb).
module kernel3_gmem_srl_store #(
  parameter int DATA_WIDTH = 32,
  parameter int ENTRIES    = 63,
  parameter int AW         = 6
) (
  input  logic                  clk,
  input  logic                  shift_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [AW-1:0]         rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [ENTRIES];

  always_ff @(posedge clk) begin
    if (shift_en) begin
      mem[0] <= wr_data;
      for (int i = 1; i < ENTRIES; i++)
        mem[i] <= mem[i-1];
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/kernel3_gmem_srl_fifo.sv
// SRL-backed FWFT FIFO with registered output and almost-full flag.
// Ports: clk, reset, clk_en; s_valid/s_ready/s_data in side;
// m_valid/m_ready/m_data out side; occupancy, almost_full status.
// Optional empty bypass: define KERNEL3_GMEM_SRL_FIFO_BYPASS_EN.
module kernel3_gmem_srl_fifo
  import kernel3_gmem_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int CNT_WIDTH  = DEF_CNT_WIDTH,
  parameter int AF_THRESH  = 60
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clk_en,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [CNT_WIDTH-1:0]  occupancy,
  output logic                  almost_full
);

  localparam int ENTRIES = (DEPTH > 1) ? DEPTH - 1 : 1;
  localparam int AW = (ENTRIES > 1) ? clog2(ENTRIES) : 1;

  if (DEPTH < 2) begin : g_bad_depth
    $error("DEPTH must be >= 2");
  end
  if (CNT_WIDTH < clog2(DEPTH + 1)) begin : g_bad_cnt
    $error("CNT_WIDTH too small for DEPTH");
  end
  if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
    $error("AF_THRESH out of range");
  end

  logic [CNT_WIDTH-1:0]  srl_cnt;
  logic [CNT_WIDTH-1:0]  srl_cnt_nxt;
  logic                  m_valid_nxt;
  logic [DATA_WIDTH-1:0] m_data_nxt;
  logic [DATA_WIDTH-1:0] srl_rd;
  logic [AW-1:0]         rd_addr;
  logic                  push;
  logic                  pop;
  logic                  out_free;
  logic                  load;
  logic                  byp;
  logic                  shift_en;

  assign s_ready  = srl_cnt < CNT_WIDTH'(DEPTH - 1);
  assign push     = clk_en & s_valid & s_ready;
  assign pop      = clk_en & m_valid & m_ready;
  assign out_free = ~m_valid | m_ready;
  assign load     = clk_en & (srl_cnt != '0) & out_free;

`ifdef KERNEL3_GMEM_SRL_FIFO_BYPASS_EN
  // Empty SRL and free output: word skips the shift array.
  assign byp = push & (srl_cnt == '0) & out_free;
`else
  assign byp = 1'b0;
`endif

  assign shift_en = push & ~byp;
  // Oldest word sits at srl_cnt-1; unused when srl_cnt is 0.
  assign rd_addr  = AW'(srl_cnt - CNT_WIDTH'(1));

  assign srl_cnt_nxt = srl_cnt + CNT_WIDTH'(shift_en)
                     - CNT_WIDTH'(load);

  always_comb begin
    m_valid_nxt = m_valid;
    m_data_nxt  = m_data;
    priority case (1'b1)
      load: begin
        m_valid_nxt = 1'b1;
        m_data_nxt  = srl_rd;
      end
      byp: begin
        m_valid_nxt = 1'b1;
        m_data_nxt  = s_data;
      end
      pop:     m_valid_nxt = 1'b0;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      srl_cnt <= '0;
      m_valid <= 1'b0;
      m_data  <= '0;
    end else begin
      srl_cnt <= srl_cnt_nxt;
      m_valid <= m_valid_nxt;
      m_data  <= m_data_nxt;
    end
  end

  assign occupancy   = srl_cnt + CNT_WIDTH'(m_valid);
  assign almost_full = occupancy >= CNT_WIDTH'(AF_THRESH);

  kernel3_gmem_srl_store #(
    .DATA_WIDTH(DATA_WIDTH),
    .ENTRIES   (ENTRIES),
    .AW        (AW)
  ) u_store (
    .clk     (clk),
    .shift_en(shift_en),
    .wr_data (s_data),
    .rd_addr (rd_addr),
    .rd_data (srl_rd)
  );

endmodule

// File: tb/tb_kernel3_gmem_srl_fifo.sv
// Scoreboard bench for kernel3_gmem_srl_fifo (DEPTH 64, AF 60).
// Input monitor queues accepted words; output monitor checks them.
module tb_kernel3_gmem_srl_fifo;
  import kernel3_gmem_pkg::*;

  localparam int DW = 32;
  localparam int D  = 64;
  localparam int CW = 7;
  localparam int AF = 60;

  logic          clk = 1'b0;
  logic          reset;
  logic          clk_en;
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] s_data;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic [CW-1:0] occupancy;
  logic          almost_full;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int occ_m   = 0;
  logic [DW-1:0] exp_q [$];

  logic          hold_chk = 1'b0;
  logic          hold_v;
  logic [DW-1:0] hold_d;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  kernel3_gmem_srl_fifo #(
    .DATA_WIDTH(DW),
    .DEPTH     (D),
    .CNT_WIDTH (CW),
    .AF_THRESH (AF)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .clk_en     (clk_en),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .occupancy  (occupancy),
    .almost_full(almost_full)
  );

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h @%0t",
               nm, act, exp, $time);
    end
  endtask

  // Input side: record every word the FIFO accepts.
  always @(negedge clk) begin
    if (!reset && clk_en && s_valid && s_ready)
      exp_q.push_back(s_data);
  end

  // Output side: check flags and popped data against the model.
  always @(negedge clk) begin
    if (reset) begin
      hold_chk = 1'b0;
    end else begin
      chk("occupancy", 64'(occupancy), 64'(occ_m));
      chk("almost_full", 64'(almost_full), 64'(occ_m >= AF));
      if (occ_m == D)
        chk("s_ready_full", 64'(s_ready), 64'd0);
      if (occ_m <= D - 2)
        chk("s_ready_free", 64'(s_ready), 64'd1);
      if (occ_m == 0)
        chk("m_valid_empty", 64'(m_valid), 64'd0);
      if (hold_chk) begin
        chk("hold_valid", 64'(m_valid), 64'(hold_v));
        chk("hold_data", 64'(m_data), 64'(hold_d));
      end
      hold_chk = !clk_en;
      hold_v   = m_valid;
      hold_d   = m_data;
      if (clk_en && m_valid && m_ready) begin
        if (exp_q.size() == 0)
          chk("pop_underflow", 64'd1, 64'd0);
        else
          chk("m_data", 64'(m_data), 64'(exp_q.pop_front()));
        occ_m--;
      end
      if (clk_en && s_valid && s_ready)
        occ_m++;
    end
  end

  task automatic do_reset();
    reset   = 1'b1;
    s_valid = 1'b0;
    m_ready = 1'b0;
    clk_en  = 1'b1;
    #2;
    exp_q.delete();
    occ_m = 0;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic wr(input logic [DW-1:0] d);
    int t;
    t = 0;
    s_valid = 1'b1;
    s_data  = d;
    while (!(s_ready && clk_en) && t < 200) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (t >= 200)
      chk("wr_timeout", 64'd1, 64'd0);
    @(posedge clk);
    #1;
    s_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    s_valid = 1'b0;
    m_ready = 1'b1;
    clk_en  = 1'b1;
    while (occupancy != 0 && t < 300) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk("drain", 64'(occupancy), 64'd0);
  endtask

  initial begin
    int c0;
    int sent;
    int budget;
    logic acc;
    logic [DW-1:0] nxt;

    reset   = 1'b1;
    clk_en  = 1'b1;
    s_valid = 1'b0;
    s_data  = '0;
    m_ready = 1'b0;
    #1;
    chk("rst_m_valid", 64'(m_valid), 64'd0);
    chk("rst_m_data", 64'(m_data), 64'd0);
    chk("rst_occ", 64'(occupancy), 64'd0);
    chk("rst_af", 64'(almost_full), 64'd0);
    do_reset();
    chk("rst_s_ready", 64'(s_ready), 64'd1);

    // Single write latency.
    repeat (3) @(posedge clk);
    #1;
    s_valid = 1'b1;
    s_data  = 32'hA5A5A5A5;
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    chk("lat_occ", 64'(occupancy), 64'd1);
`ifdef KERNEL3_GMEM_SRL_FIFO_BYPASS_EN
    chk("lat_valid_1", 64'(m_valid), 64'd1);
`else
    chk("lat_valid_1", 64'(m_valid), 64'd0);
`endif
    @(posedge clk);
    #1;
    chk("lat_valid_2", 64'(m_valid), 64'd1);
    chk("lat_data", 64'(m_data), 64'hA5A5A5A5);

    // Fill to full.
    do_reset();
    for (int i = 0; i < D; i++) begin
      wr(DW'(i + 1));
      chk("fill_af", 64'(almost_full), 64'(i + 1 >= 60));
    end
    chk("full_s_ready", 64'(s_ready), 64'd0);
    chk("full_occ", 64'(occupancy), 64'd64);
    s_valid = 1'b1;
    s_data  = 32'hDEAD0000;
    repeat (3) @(posedge clk);
    #1;
    s_valid = 1'b0;
    chk("full_reject", 64'(occupancy), 64'd64);

    // Streaming from full.
    m_ready = 1'b1;
    c0 = cyc;
    for (int i = 0; i < 200; i++) begin
      wr(DW'(1000 + i));
      chk("stream_occ", 64'(occupancy >= 63 && occupancy <= 64),
          64'd1);
    end
    chk("stream_cycles", 64'(cyc - c0), 64'd201);
    drain();

    // Push and load on the same edge with srl_cnt == 1.
    do_reset();
    wr(32'h11);
    wr(32'h22);
    chk("pl_pre_occ", 64'(occupancy), 64'd2);
    chk("pl_pre_data", 64'(m_data), 64'h11);
    m_ready = 1'b1;
    wr(32'h33);
    chk("pl_data", 64'(m_data), 64'h22);
    chk("pl_occ", 64'(occupancy), 64'd2);
    @(posedge clk);
    #1;
    chk("pl_next", 64'(m_data), 64'h33);
    drain();

    // Asynchronous reset mid-cycle at occupancy 37.
    do_reset();
    for (int i = 0; i < 37; i++)
      wr(DW'(32'h7000 + i));
    chk("mid_occ", 64'(occupancy), 64'd37);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_m_valid", 64'(m_valid), 64'd0);
    chk("arst_occ", 64'(occupancy), 64'd0);
    chk("arst_af", 64'(almost_full), 64'd0);
    do_reset();
    for (int i = 0; i < 3; i++)
      wr(DW'(32'h5000 + i));
    drain();
    chk("arst_q", 64'(exp_q.size()), 64'd0);

    // Random traffic with clk_en gaps.
    sent   = 0;
    budget = 0;
    nxt    = 32'h10000000;
    while (sent < 10000 && budget < 60000) begin
      clk_en  = ($urandom_range(9) != 0);
      m_ready = ($urandom_range(3) != 0);
      s_valid = ($urandom_range(3) != 0);
      s_data  = nxt;
      @(negedge clk);
      acc = clk_en & s_valid & s_ready;
      @(posedge clk);
      #1;
      budget++;
      if (acc) begin
        sent++;
        nxt++;
      end
    end
    chk("rand_sent", 64'(sent), 64'd10000);
    drain();
    chk("final_q", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
